fifo_sram_level: RTL and testbench
==================================

# fifo_sram_level

Parametrised show-ahead FIFO built on the `sram_dualport` macro. It hides the one-cycle SRAM read latency with a prefetch/bypass register. It supports any `DEPTH >= 2`, including non-powers-of-two. It adds occupancy count, threshold flags and overflow/underflow pulses, and is the standard buffer between streaming producers and consumers where the flow controller needs fill level rather than just full/empty.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 8: number of entries, at least 2, any integer.
- `AF_LEVEL`, DEPTH-1: `almost_full_o` asserts when count >= AF_LEVEL; range 1..DEPTH.
- `AE_LEVEL`, 1: `almost_empty_o` asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `wr_en_i`  in  1  write request.
- `rd_en_i`  in  1  read request; consumes the current head word.
- `data_i`  in  WIDTH  write data.
- `data_o`  out  WIDTH  head word (show-ahead); valid whenever `empty_o`=0.
- `empty_o`, `full_o`  out  1  occupancy = 0 / occupancy = DEPTH.
- `almost_empty_o`, `almost_full_o`  out  1  threshold flags.
- `count_o`  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH.
- `overflow_o`, `underflow_o`  out  1  one-cycle error pulses.

## Operation
- Accept rules, evaluated on the current registered state:
  - push = `wr_en_i` & (~full | `rd_en_i`).
  - pop = `rd_en_i` & ~empty.
  - When full and both requests are asserted, both are accepted.
  - When empty and both are asserted, only the push is accepted.
- Pointers `wr_ptr` / `rd_ptr` are $clog2(DEPTH) bits wide. They wrap from DEPTH-1 to 0. A lap bit toggles on each wrap, and full/empty is decided by pointer equality plus lap bits.
- `count_o` is a register with these updates:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
  - It must always equal the pointer difference, which is a bench assertion.
- Threshold flags, `empty_o` and `full_o` are registered from the next-state count. They are never combinational from `wr_en_i` or `rd_en_i`.
- SRAM `sram_dualport`:
  - Write port at `wr_ptr`; read port at prefetch_ptr = `rd_ptr`+1, with wrap.
  - rdata updates one cycle after `ren`.
  - `wen` = push & ~bypass_load.
  - `ren` = pop & (count > 2) & ~... More precisely: `ren` = pop & prefetch_ptr ≠ `wr_ptr`.
- Bypass register, loaded when push & (empty | (count = 1 & pop)):
  - bypass_valid is set on load.
  - bypass_valid is cleared on pop without load.
  - `data_o` = bypass_valid ? bypass_data : SRAM rdata.
- Error pulses:
  - `overflow_o` = `wr_en_i` & full & ~`rd_en_i`.
  - `underflow_o` = `rd_en_i` & empty.
  - Both are registered, so they appear in the cycle after the offending request. The rejected operation has no other effect.
- Parameter checks: elaboration fails if DEPTH < 2, AF_LEVEL is outside 1..DEPTH, or AE_LEVEL >= DEPTH.

## Timing
- Reset values (asynchronous, immediate): pointers, lap bits and count = 0; `empty_o`=1, `almost_empty_o`=1 (AE_LEVEL >= 0); `full_o`, `almost_full_o`, `overflow_o`, `underflow_o`, bypass_valid = 0. `data_o` is don't-care while empty.
- Reset asserted mid-operation discards all contents. The first push after deassertion behaves as a push into an empty FIFO.
- Write-to-read latency is 1 cycle:
  - A push at edge N clears `empty_o` after edge N.
  - The word is on `data_o` during cycle N+1 and can be popped at edge N+1.
- Show-ahead: after a pop at edge N, the next word is on `data_o` during cycle N+1, whether it comes from SRAM prefetch or bypass. There are no bubbles at any fill level.
- Full throughput: push and pop in every cycle is sustained indefinitely at any occupancy, including 0/1 (bypass swap) and DEPTH (simultaneous accept).
- All flags and `count_o` change only on a clock edge; each reflects the state after that edge.

## Test plan
Configuration: WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
- Reset, then push 0x11..0x15 on consecutive cycles with no reads.
  - `count_o` steps 1..5.
  - `almost_empty_o` drops at count 2; `almost_full_o` rises at count 4; `full_o` at 5.
  - `data_o`=0x11 from the cycle after the first push.
- From full, push 0xAA without read → `overflow_o` pulses one cycle, contents unchanged. Then pop 5 times → outputs 0x11..0x15 in order, `empty_o`=1 after the last pop.
- Pop while empty → `underflow_o` pulses one cycle; count stays 0.
- From empty, push and pop every cycle with data 0x20,0x21,… for 20 cycles → `data_o` shows each word the cycle after its push, count toggles 0→1 then stays 1, and no SRAM write occurs (bypass path only).
- At count=5, simultaneous push 0x99 and pop → old head is removed, count stays 5, and 0x99 emerges last after draining. Wrap across index 4→0 at least 3 times with random traffic, checked against a reference queue.
- Assert `rst_i` asynchronously mid-burst at count=3 → `empty_o`=1 and count=0 immediately. A subsequent push of 0x42 → `data_o`=0x42 next cycle.

Source files
------------

// File: rtl/fifo_sram_level_if.sv
// Handshake and status bundle for fifo_sram_level.
// The master side is the producer/consumer pair; the slave side is the FIFO.
interface fifo_sram_level_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();
  logic                         wr_en_i;
  logic                         rd_en_i;
  logic [WIDTH-1:0]             data_i;
  logic [WIDTH-1:0]             data_o;
  logic                         empty_o;
  logic                         full_o;
  logic                         almost_empty_o;
  logic                         almost_full_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  logic                         overflow_o;
  logic                         underflow_o;

  modport master (
    output wr_en_i, rd_en_i, data_i,
    input  data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, rd_en_i, data_i,
    output data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_sram_level.sv
// Show-ahead FIFO over a registered-read dual-port SRAM. A bypass register
// holds the head word whenever the SRAM cannot have it ready in time, so the
// head is valid the cycle after any push or pop at every fill level.

// Behavioural model of the dual-port SRAM macro: synchronous write, registered read.
module sram_dualport #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and read port; rdata holds its value when not reading.
  always_ff @(posedge clk_i) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end
endmodule

module fifo_sram_level #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fifo_sram_level_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sram_level: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sram_level: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_sram_level: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr, prefetch_ptr;
  logic             wr_lap, rd_lap;
  logic [CW-1:0]    count, count_nxt;
  logic             ptr_eq, is_empty, is_full;
  logic             push, pop, bypass_load;
  logic             sram_wen, sram_ren;
  logic             bypass_valid;
  logic [WIDTH-1:0] bypass_data, sram_rdata;
  logic             empty_q, full_q, ae_q, af_q, ovf_q, unf_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Accept decisions, SRAM port controls and next occupancy from registered state.
  always_comb begin
    ptr_eq       = (wr_ptr == rd_ptr);
    is_empty     = ptr_eq & (wr_lap == rd_lap);
    is_full      = ptr_eq & (wr_lap != rd_lap);
    push         = bus.wr_en_i & (~is_full | bus.rd_en_i);
    pop          = bus.rd_en_i & ~is_empty;
    prefetch_ptr = ptr_inc(rd_ptr);
    // The new word becomes the head next cycle: SRAM read latency cannot cover it.
    bypass_load  = push & (is_empty | ((count == CW'(1)) & pop));
    sram_wen     = push & ~bypass_load;
    // Prefetch the word behind the head unless that slot has not been written yet.
    sram_ren     = pop & (prefetch_ptr != wr_ptr);
    count_nxt    = count;
    if (push & ~pop)      count_nxt = count + CW'(1);
    else if (pop & ~push) count_nxt = count - CW'(1);
  end

  // Pointer and lap-bit advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_lap <= 1'b0;
      rd_lap <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (wr_ptr == AW'(DEPTH - 1)) wr_lap <= ~wr_lap;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        if (rd_ptr == AW'(DEPTH - 1)) rd_lap <= ~rd_lap;
      end
    end
  end

  // Occupancy count, level flags and error pulses, all registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CW'(DEPTH));
      ae_q    <= (count_nxt <= CW'(AE_LEVEL));
      af_q    <= (count_nxt >= CW'(AF_LEVEL));
      ovf_q   <= bus.wr_en_i & is_full & ~bus.rd_en_i;
      unf_q   <= bus.rd_en_i & is_empty;
    end
  end

  // Bypass head register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bypass_valid <= 1'b0;
      bypass_data  <= '0;
    end else if (bypass_load) begin
      bypass_valid <= 1'b1;
      bypass_data  <= bus.data_i;
    end else if (pop) begin
      bypass_valid <= 1'b0;
    end
  end

  sram_dualport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk_i (clk_i),
    .wen   (sram_wen),
    .waddr (wr_ptr),
    .wdata (bus.data_i),
    .ren   (sram_ren),
    .raddr (prefetch_ptr),
    .rdata (sram_rdata)
  );

  assign bus.data_o         = bypass_valid ? bypass_data : sram_rdata;
  assign bus.empty_o        = empty_q;
  assign bus.full_o         = full_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.almost_full_o  = af_q;
  assign bus.count_o        = count;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_fifo_sram_level.sv
// Directed bench for fifo_sram_level (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1).
module tb_fifo_sram_level;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_sram_level_if #(.WIDTH(8), .DEPTH(5)) bus ();

  fifo_sram_level #(
    .WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  logic [7:0] q[$];
  int mwp = 0;
  int mrp = 0;

  always @(posedge clk) if (dut.sram_wen === 1'b1) wen_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of requests, then compare every output with the reference queue.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
    bit full, empty, push, pop, eovf, eunf;
    full  = (q.size() == 5);
    empty = (q.size() == 0);
    push  = wr && (!full || rd);
    pop   = rd && !empty;
    eovf  = wr && full && !rd;
    eunf  = rd && empty;
    if (pop) begin
      void'(q.pop_front());
      mrp = (mrp + 1) % 5;
    end
    if (push) begin
      q.push_back(d);
      mwp = (mwp + 1) % 5;
    end
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.data_i  = d;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    chk("count", 32'(bus.count_o), 32'(q.size()));
    chk("empty", 32'(bus.empty_o), 32'(q.size() == 0));
    chk("full", 32'(bus.full_o), 32'(q.size() == 5));
    chk("almost_empty", 32'(bus.almost_empty_o), 32'(q.size() <= 1));
    chk("almost_full", 32'(bus.almost_full_o), 32'(q.size() >= 4));
    chk("overflow", 32'(bus.overflow_o), 32'(eovf));
    chk("underflow", 32'(bus.underflow_o), 32'(eunf));
    chk("wr_ptr", 32'(dut.wr_ptr), 32'(mwp));
    chk("rd_ptr", 32'(dut.rd_ptr), 32'(mrp));
    if (q.size() != 0) chk("data_o", 32'(bus.data_o), 32'(q[0]));
  endtask

  initial begin
    int wen_before;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.data_i  = 8'h00;

    // Reset state
    #12;
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_ae", 32'(bus.almost_empty_o), 32'd1);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_af", 32'(bus.almost_full_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
    chk("rst_unf", 32'(bus.underflow_o), 32'd0);
    rst = 1'b0;

    // Fill 0x11..0x15
    cyc(1, 0, 8'h11);
    chk("first_head", 32'(bus.data_o), 32'h11);
    chk("cnt1_ae", 32'(bus.almost_empty_o), 32'd1);
    cyc(1, 0, 8'h12);
    chk("cnt2_ae", 32'(bus.almost_empty_o), 32'd0);
    cyc(1, 0, 8'h13);
    chk("cnt3_af", 32'(bus.almost_full_o), 32'd0);
    cyc(1, 0, 8'h14);
    chk("cnt4_af", 32'(bus.almost_full_o), 32'd1);
    chk("cnt4_full", 32'(bus.full_o), 32'd0);
    cyc(1, 0, 8'h15);
    chk("cnt5_full", 32'(bus.full_o), 32'd1);
    chk("cnt5_head", 32'(bus.data_o), 32'h11);

    // Overflow, then drain in order
    cyc(1, 0, 8'hAA);
    chk("ovf_pulse", 32'(bus.overflow_o), 32'd1);
    chk("ovf_count", 32'(bus.count_o), 32'd5);
    cyc(0, 0, 8'h00);
    chk("ovf_clear", 32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("drain_head", 32'(bus.data_o), 32'(8'h11 + i));
      cyc(0, 1, 8'h00);
    end
    chk("drained_empty", 32'(bus.empty_o), 32'd1);

    // Underflow
    cyc(0, 1, 8'h00);
    chk("unf_pulse", 32'(bus.underflow_o), 32'd1);
    chk("unf_count", 32'(bus.count_o), 32'd0);
    cyc(0, 0, 8'h00);
    chk("unf_clear", 32'(bus.underflow_o), 32'd0);

    // Streaming through the bypass register from empty
    wen_before = wen_cnt;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 8'(8'h20 + i));
      chk("stream_head", 32'(bus.data_o), 32'(8'h20 + i));
      chk("stream_count", 32'(bus.count_o), 32'd1);
    end
    chk("stream_no_sram_wr", 32'(wen_cnt - wen_before), 32'd0);
    cyc(0, 1, 8'h00);

    // Simultaneous push/pop at full
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i));
    cyc(1, 1, 8'h99);
    chk("full_swap_count", 32'(bus.count_o), 32'd5);
    chk("full_swap_head", 32'(bus.data_o), 32'h31);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);
    chk("last_is_99", 32'(bus.data_o), 32'h99);
    cyc(0, 1, 8'h00);

    // Random traffic with wraparound
    for (int i = 0; i < 80; i++)
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0),
          8'($urandom_range(0, 255)));
    while (q.size() != 0) cyc(0, 1, 8'h00);

    // Asynchronous reset mid-burst at count 3
    cyc(1, 0, 8'h51);
    cyc(1, 0, 8'h52);
    cyc(1, 0, 8'h53);
    chk("pre_rst_count", 32'(bus.count_o), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_empty", 32'(bus.empty_o), 32'd1);
    chk("async_rst_count", 32'(bus.count_o), 32'd0);
    q.delete();
    mwp = 0;
    mrp = 0;
    #2 rst = 1'b0;
    cyc(1, 0, 8'h42);
    chk("post_rst_head", 32'(bus.data_o), 32'h42);
    cyc(0, 1, 8'h00);
    chk("post_rst_empty", 32'(bus.empty_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
